// File: rtl/mux2_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_arbiter
//
// Round-robin arbiter and sequencer for a shared WIDTH-bit 2:1 mux datapath.
// Two producers (req0/d0 and req1/d1) compete for the path; the arbiter owns
// the mux select, grants one requester at a time, and captures the selected
// word into a single registered output slot (y/valid) drained by a
// valid/ready handshake. A tenure is capped at MAX_BURST transfers while the
// other requester is waiting; with no competition the owner keeps the path.
//
// Parameters
//   WIDTH      data width of d0, d1 and y
//   MAX_BURST  transfers per tenure while the other side waits (>= 1)
//
// Ports
//   clk    in   system clock, all state changes on the rising edge
//   rst_n  in   synchronous active-low reset
//   req0   in   requester 0 wants the path
//   d0     in   requester 0 data
//   gnt0   out  requester 0 owns the path
//   req1   in   requester 1 wants the path
//   d1     in   requester 1 data
//   gnt1   out  requester 1 owns the path
//   sel    out  mux select (0 = d0, 1 = d1)
//   y      out  registered selected data
//   valid  out  y holds an unconsumed word
//   ready  in   downstream accepts y this cycle
// ---------------------------------------------------------------------------
module mux2_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    input  logic             ready
);

    // Counter wide enough to hold MAX_BURST itself (it saturates there).
    localparam int              CNT_W   = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_owner;
    logic             r_sel;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    logic [1:0]       w_state_next;
    logic             w_owning;
    logic             w_owner;
    logic             w_own_req;
    logic             w_other_req;
    logic             w_xfer;
    logic             w_leave;
    logic [WIDTH-1:0] w_owner_data;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_next;

    // -----------------------------------------------------------------------
    // Owner-relative view: everything below is expressed as "own" vs "other"
    // so OWN0 and OWN1 share one set of transfer/release equations.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_owning     = (r_state == ST_OWN0) || (r_state == ST_OWN1);
        w_owner      = (r_state == ST_OWN1);
        w_own_req    = w_owner ? req1 : req0;
        w_other_req  = w_owner ? req0 : req1;
        w_owner_data = w_owner ? d1 : d0;

        // A transfer needs the owner still requesting and a free (or freeing)
        // output slot; this is also what stalls the owner under backpressure.
        w_xfer = w_owning && w_own_req && (!r_valid || ready);

        w_cnt_inc  = (r_burst_cnt == CNT_MAX) ? r_burst_cnt : r_burst_cnt + CNT_W'(1);
        w_cnt_next = w_xfer ? w_cnt_inc : r_burst_cnt;

        // Release uses the post-transfer count so the cap-reaching transfer and
        // the hand-over happen on the same edge. A saturated count hands over
        // as soon as the other side raises its request.
        w_leave = w_owning &&
                  (!w_own_req || (w_other_req && (w_cnt_next >= CNT_MAX)));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    // Tie goes to whoever did not own the path last.
                    w_state_next = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    w_state_next = ST_OWN0;
                end else if (req1) begin
                    w_state_next = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (w_leave) begin
                    // Direct hand-over to a waiting requester, no IDLE bubble.
                    if (w_other_req) begin
                        w_state_next = w_owner ? ST_OWN0 : ST_OWN1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;  // unused encoding recovers to IDLE
        endcase
    end

    // -----------------------------------------------------------------------
    // State, arbitration history and output slot.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;        // requester 0 wins the first tie
            r_sel        <= 1'b0;
            r_burst_cnt  <= '0;
            r_y          <= '0;
            r_valid      <= 1'b0;        // pending word is dropped, no handshake
        end else begin
            r_state <= w_state_next;

            if (w_leave) begin
                r_last_owner <= w_owner;
                r_burst_cnt  <= '0;
            end else begin
                r_burst_cnt  <= w_cnt_next;
            end

            // sel follows the owner and simply holds through IDLE, so it keeps
            // pointing at the last owner without a separate decode.
            if (w_state_next == ST_OWN0) begin
                r_sel <= 1'b0;
            end else if (w_state_next == ST_OWN1) begin
                r_sel <= 1'b1;
            end

            // Single output slot: a transfer overwrites (back-to-back when the
            // slot is being consumed), a bare consume empties it.
            if (w_xfer) begin
                r_y     <= w_owner_data;
                r_valid <= 1'b1;
            end else if (ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign gnt0  = (r_state == ST_OWN0);
    assign gnt1  = (r_state == ST_OWN1);
    assign sel   = r_sel;
    assign y     = r_y;
    assign valid = r_valid;

    // Grants are one-hot-or-zero by construction of the state decode.
    a_gnt_exclusive : assert property (@(posedge clk) !(gnt0 && gnt1));

endmodule

// File: tb/tb_mux2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_arbiter
//
// Scoreboard bench: a behavioural model (owner as an integer, tenure length,
// one-slot output occupancy) predicts every accepted word and pushes it into
// an expected queue; an independent monitor pops and compares whenever the
// DUT completes a valid/ready handshake. Grant/select/valid are compared
// against the model every cycle. Directed scenarios first, then random.
// ---------------------------------------------------------------------------
module tb_mux2_arbiter;

    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic [WIDTH-1:0] d0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] d1;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic             ready;

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .d0    (d0),
        .gnt0  (gnt0),
        .req1  (req1),
        .d1    (d1),
        .gnt1  (gnt1),
        .sel   (sel),
        .y     (y),
        .valid (valid),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_owner  = -1;    // -1 = nobody owns the path
    int               m_last   = 1;
    int               m_tenure = 0;     // words moved in current tenure (capped)
    bit               m_full   = 1'b0;  // output slot occupied
    bit               m_sel    = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    // Applies the rules for one rising edge using the inputs present at it.
    task automatic model_edge();
        bit               r[2];
        logic [WIDTH-1:0] dv[2];
        int               o;
        bit               take;
        r[0] = req0; r[1] = req1; dv[0] = d0; dv[1] = d1;
        if (!rst_n) begin
            m_owner = -1; m_last = 1; m_tenure = 0; m_full = 1'b0; m_sel = 1'b0;
            exp_q.delete();
        end else begin
            o    = m_owner;
            take = (o >= 0) && r[o] && (!m_full || ready);
            if (take) begin
                exp_q.push_back(dv[o]);
                if (m_tenure < MAX_BURST) m_tenure++;
            end
            m_full = take ? 1'b1 : (ready ? 1'b0 : m_full);
            if (o < 0) begin
                if (r[0] && r[1]) m_owner = 1 - m_last;
                else if (r[0])    m_owner = 0;
                else if (r[1])    m_owner = 1;
            end else if (!r[o] || (r[1-o] && m_tenure >= MAX_BURST)) begin
                m_last   = o;
                m_tenure = 0;
                m_owner  = r[1-o] ? 1 - o : -1;
            end
            if (m_owner >= 0) m_sel = (m_owner == 1);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after.
    task automatic cyc(input logic rn, input logic q0, input logic q1,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic rd);
        rst_n = rn; req0 = q0; req1 = q1; d0 = a; d1 = b; ready = rd;
        @(posedge clk);
        model_edge();
        #1;
        check("gnt0",  gnt0,  (m_owner == 0));
        check("gnt1",  gnt1,  (m_owner == 1));
        check("sel",   sel,   m_sel);
        check("valid", valid, m_full);
        check("gnt_excl", (gnt0 && gnt1), 1'b0);
    endtask

    // ---------------- monitor: handshake-driven scoreboard ----------------
    // Inputs change 1 time unit after posedge, so at negedge they already
    // hold the values the next edge will see.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", y, 32'hDEAD);
            end else begin
                check("y_word", y, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic q0, q1;
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; d0 = '0; d1 = '0; ready = 1'b1;

        // Reset with both requesting.
        cyc(0, 1, 1, 4'h0, 4'h0, 1);
        cyc(0, 1, 1, 4'h0, 4'h0, 1);
        check("rst_y", y, 4'h0);
        check("rst_sel", sel, 1'b0);
        cyc(1, 1, 1, 4'hF, 4'h0, 1);
        check("first_tie_gnt0", gnt0, 1'b1);

        // Single requester 0.
        cyc(1, 1, 0, 4'b1111, 4'h0, 1);
        check("single_y", y, 4'b1111);
        cyc(1, 0, 0, 4'b1111, 4'h0, 1);
        check("single_drain_valid", valid, 1'b0);

        // Backpressure on requester 1.
        cyc(1, 0, 1, 4'h0, 4'b1011, 0);
        cyc(1, 0, 1, 4'h0, 4'b1011, 0);
        check("bp_first_y", y, 4'b1011);
        cyc(1, 0, 1, 4'h0, 4'b0001, 0);
        check("bp_hold_y", y, 4'b1011);
        cyc(1, 0, 1, 4'h0, 4'b0001, 1);
        check("bp_release_y", y, 4'b0001);
        cyc(1, 0, 0, 4'h0, 4'h0, 1);
        cyc(1, 0, 0, 4'h0, 4'h0, 1);

        // Burst cap with both requesting continuously.
        for (int i = 0; i < 20; i++)
            cyc(1, 1, 1, WIDTH'($urandom), WIDTH'($urandom), 1);
        cyc(1, 0, 0, 4'h0, 4'h0, 1);
        cyc(1, 0, 0, 4'h0, 4'h0, 1);

        // Tie rotation: direct OWN0 -> OWN1, then fresh tie goes to 0.
        cyc(1, 1, 0, 4'h3, 4'h0, 1);
        cyc(1, 1, 1, 4'h4, 4'h9, 1);
        cyc(1, 1, 1, 4'h5, 4'h9, 1);
        cyc(1, 0, 1, 4'h0, 4'hA, 1);
        check("rot_gnt1", gnt1, 1'b1);
        check("rot_sel", sel, 1'b1);
        cyc(1, 0, 1, 4'h0, 4'hB, 1);
        cyc(1, 0, 0, 4'h0, 4'h0, 1);
        cyc(1, 1, 1, 4'h6, 4'hC, 1);
        check("rot_tie_gnt0", gnt0, 1'b1);

        // Mid-operation reset with a pending word.
        cyc(1, 1, 0, 4'h7, 4'h0, 0);
        cyc(1, 1, 0, 4'h8, 4'h0, 0);
        check("mid_pending_valid", valid, 1'b1);
        cyc(0, 1, 0, 4'h8, 4'h0, 0);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_y", y, 4'h0);
        check("mid_rst_gnt0", gnt0, 1'b0);

        // Randomized traffic: sticky requests, random backpressure, rare reset.
        q0 = 1'b0; q1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) q0 = ~q0;
            if ($urandom_range(3) == 0) q1 = ~q1;
            cyc(($urandom_range(199) != 0), q0, q1,
                WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
